if_stage_dual: RTL and testbench
================================

Name: if_stage_dual

Overview:
- Dual-issue fetch stage plus IF/ID pipeline register, sitting directly upstream of the decode/control stage.
- Each cycle it presents two sequential fetch addresses to the asynchronous instruction memory and decides whether the pair can issue together.
- It registers one or two instructions with valid flags for decode, and advances the PC by 8 (pair issued) or 4 (slot 0 only).
- It honours stall and redirect (jump/jr/branch resolved in ID) requests.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word driven in an invalid slot (sll $0,$0,0).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents.
- redirect  in  1  control transfer taken in ID; flush and reload the PC.
- redirect_pc  in  32  target PC when redirect=1.
- imem_addr0  out  32  fetch address for slot 0; equals pc.
- imem_addr1  out  32  fetch address for slot 1; equals pc+4 (mod 2^32).
- imem_data0  in  32  instruction at imem_addr0, same cycle (combinational read).
- imem_data1  in  32  instruction at imem_addr1, same cycle.
- pc  out  32  current fetch PC.
- ifid_instr0  out  32  registered slot-0 instruction.
- ifid_instr1  out  32  registered slot-1 instruction; NOP_WORD when ifid_valid1=0.
- ifid_pc0  out  32  PC of ifid_instr0.
- ifid_pc1  out  32  ifid_pc0+4.
- ifid_valid0  out  1  slot 0 holds a real instruction.
- ifid_valid1  out  1  slot 1 issued in the same cycle as slot 0.

Behaviour:
- Reset (rst=1 at clock edge):
  - pc=RESET_PC.
  - ifid_instr0/1=NOP_WORD, ifid_pc0/1=0, ifid_valid0/1=0.
  - rst overrides every other input.
- Priority per edge: rst > redirect > stall > normal.
- Normal (no stall, no redirect):
  - IF/ID <= {imem_data0, pc, valid0=1}.
  - Slot 1 <= imem_data1 with valid1=pair_ok; otherwise NOP_WORD with valid1=0.
  - pc <= pc+8 if pair_ok, else pc+4. Arithmetic is 32-bit with wrap (32'hFFFF_FFFC+8 = 32'h0000_0004).
- Latency: an instruction at address A, fetched with pc=A, appears on ifid_* exactly one cycle later.
- Stall: pc and all ifid_* hold; the imem addresses keep presenting the current pc.
- Redirect: pc <= redirect_pc; ifid_valid0/1 <= 0 and instrs <= NOP_WORD. No delay slot. Redirect wins over a simultaneous stall.
- pair_ok is combinational on imem_data0/1. It is 0 if any of the following holds:
  - Slot 0 is a control transfer: opcode BEQ 000100, BNE 000101, J 000010, JAL 000011, or R-type with funct JR 001000. Control transfers only ever execute in slot 0.
  - Slot 1 is a control transfer (same set). It issues as slot 0 in the next cycle.
  - Both slots are memory ops (LW 100011 / SW 101011). There is a single data-memory port.
  - RAW hazard: slot 0 dest != 0 and slot 1 reads dest.
    - Slot 0 dest: rd for R-type (non-JR), rt for LW/ADDI/ORI/XORI/ANDI/SLTI, 31 for JAL.
    - Slot 1 reads: rs always; rt also for R-type, SW, BEQ, BNE.
  - WAW hazard: both slots write the same nonzero dest.
- Unknown opcodes are treated as non-writing and non-memory, so they are pairable unless another rule blocks them.
- Reset mid-stall or mid-redirect: reset state on the next edge; fetch restarts at RESET_PC.
- No combinational path from stall/redirect to imem_addr*. Addresses derive only from the pc register.

Decomposition:
- Shared package isa_defs holds:
  - opcode constants: R_TYPE, LW, SW, BEQ, BNE, ADDI, ORI, XORI, ANDI, SLTI, J, JAL;
  - funct constants: ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, SGT, JR;
  - NOP_WORD and the JAL link register index 31.
- The control unit is migrated to the same package.
- Sub-module pair_check: purely combinational; inputs instr0, instr1; output pair_ok. It contains the dest/source extraction and all hazard rules, and is unit-tested standalone.

Test Plan:
- Reset then release with imem returning ADD $3,$1,$2 / ADD $4,$5,$6: cycle 1 ifid_valid0=1, ifid_valid1=1, ifid_pc0=0; pc=8.
- RAW pair ADDI $8,$0,5 then ADD $9,$8,$8 at pc=0x10: ifid_valid1=0, ifid_instr1=0, pc=0x14; the next cycle issues ADD at ifid_pc0=0x14.
- LW $2,0($1) with SW $3,4($4): not paired, pc advances by 4. LW $2,0($1) with ADD $5,$6,$7: paired, pc advances by 8.
- BEQ in slot 0 at pc=0x20: valid1=0, pc=0x24. Then redirect=1, redirect_pc=0x100 asserted with stall=1: next cycle pc=0x100, ifid_valid0=ifid_valid1=0.
- Stall held 3 cycles after pc=0x40 fetch: pc and ifid_* unchanged throughout; on release the pair at 0x40 issues normally.
- pc=32'hFFFF_FFF8 with pairable pair: pc wraps to 32'h0000_0000. rst asserted during a stall: pc=RESET_PC and valids=0 next edge.

Source files
------------

// File: rtl/isa_defs_pkg.sv
// isa_defs: MIPS opcode/funct constants, instruction layout and decode helpers shared by fetch and control
package isa_defs;
  localparam logic [5:0] R_TYPE = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] ADDI = 6'h08, SLTI = 6'h0A, ANDI = 6'h0C, ORI = 6'h0D, XORI = 6'h0E;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2B;
  localparam logic [5:0] SLL = 6'h00, SRL = 6'h02, JR = 6'h08, ADD = 6'h20, SUB = 6'h22;
  localparam logic [5:0] AND = 6'h24, OR = 6'h25, XOR = 6'h26, NOR = 6'h27, SLT = 6'h2A, SGT = 6'h2C;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [4:0] LINK_REG = 5'd31;
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;
  function automatic logic is_ctl(instr_t i);
    return i.op inside {BEQ, BNE, J, JAL} || (i.op == R_TYPE && i.funct == JR);
  endfunction
  function automatic logic is_mem(instr_t i);
    return i.op inside {LW, SW};
  endfunction
  function automatic logic reads_rt(instr_t i);
    return i.op inside {R_TYPE, SW, BEQ, BNE};
  endfunction
  // Non-writing and unknown opcodes report register 0, which never hazards.
  function automatic logic [4:0] dest_of(instr_t i);
    return (i.op == R_TYPE && i.funct != JR) ? i.rd :
           (i.op inside {LW, ADDI, ORI, XORI, ANDI, SLTI}) ? i.rt :
           (i.op == JAL) ? LINK_REG : 5'd0;
  endfunction
  function automatic logic [4:0] rs_of(instr_t i);
    return i.rs;
  endfunction
  function automatic logic [4:0] rt_of(instr_t i);
    return i.rt;
  endfunction
endpackage

// File: rtl/if_stage_dual_pair_check.sv
// pair_check: decides whether two sequential instructions may issue together
module pair_check
  import isa_defs::*;
(
  input  logic [31:0] instr0,
  input  logic [31:0] instr1,
  output logic        pair_ok
);
  logic [4:0] d0, d1;
  logic raw, waw;
  always_comb begin
    d0 = dest_of(instr0);
    d1 = dest_of(instr1);
    raw = d0 != 5'd0 && (rs_of(instr1) == d0 || (reads_rt(instr1) && rt_of(instr1) == d0));
    waw = d0 != 5'd0 && d0 == d1;
    pair_ok = !(is_ctl(instr0) || is_ctl(instr1) || (is_mem(instr0) && is_mem(instr1)) || raw || waw);
  end
endmodule

// File: rtl/if_stage_dual.sv
// if_stage_dual: dual-issue fetch stage with IF/ID register, stall and redirect
module if_stage_dual #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = isa_defs::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr0,
  output logic [31:0] imem_addr1,
  input  logic [31:0] imem_data0,
  input  logic [31:0] imem_data1,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr0,
  output logic [31:0] ifid_instr1,
  output logic [31:0] ifid_pc0,
  output logic [31:0] ifid_pc1,
  output logic        ifid_valid0,
  output logic        ifid_valid1
);
  logic [31:0] pc_q, pc_d, instr0_q, instr0_d, instr1_q, instr1_d, pc0_q, pc0_d, pc1_q, pc1_d;
  logic valid0_q, valid0_d, valid1_q, valid1_d, pair_ok;
  pair_check u_pair (.instr0(imem_data0), .instr1(imem_data1), .pair_ok(pair_ok));
  always_comb begin
    pc_d = redirect ? redirect_pc : stall ? pc_q : pc_q + (pair_ok ? 32'd8 : 32'd4);
    instr0_d = redirect ? NOP_WORD : stall ? instr0_q : imem_data0;
    instr1_d = redirect ? NOP_WORD : stall ? instr1_q : pair_ok ? imem_data1 : NOP_WORD;
    pc0_d = (redirect || stall) ? pc0_q : pc_q;
    pc1_d = (redirect || stall) ? pc1_q : pc_q + 32'd4;
    valid0_d = redirect ? 1'b0 : stall ? valid0_q : 1'b1;
    valid1_d = redirect ? 1'b0 : stall ? valid1_q : pair_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      instr0_q <= NOP_WORD;
      instr1_q <= NOP_WORD;
      pc0_q <= 32'd0;
      pc1_q <= 32'd0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      pc0_q <= pc0_d;
      pc1_q <= pc1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
    end
  end
  assign imem_addr0 = pc_q;
  assign imem_addr1 = pc_q + 32'd4;
  assign pc = pc_q;
  assign ifid_instr0 = instr0_q;
  assign ifid_instr1 = instr1_q;
  assign ifid_pc0 = pc0_q;
  assign ifid_pc1 = pc1_q;
  assign ifid_valid0 = valid0_q;
  assign ifid_valid1 = valid1_q;
endmodule

// File: tb/tb_if_stage_dual.sv
// tb_if_stage_dual: directed vectors for the fetch stage and standalone pair_check
module tb_if_stage_dual;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0, imem_data0 = 32'd0, imem_data1 = 32'd0;
  logic [31:0] imem_addr0, imem_addr1, pc, ifid_instr0, ifid_instr1, ifid_pc0, ifid_pc1;
  logic ifid_valid0, ifid_valid1;
  logic [31:0] pi0 = 32'd0, pi1 = 32'd0;
  logic pok;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  if_stage_dual dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr0(imem_addr0), .imem_addr1(imem_addr1), .imem_data0(imem_data0), .imem_data1(imem_data1),
    .pc(pc), .ifid_instr0(ifid_instr0), .ifid_instr1(ifid_instr1), .ifid_pc0(ifid_pc0),
    .ifid_pc1(ifid_pc1), .ifid_valid0(ifid_valid0), .ifid_valid1(ifid_valid1)
  );
  pair_check u_pc (.instr0(pi0), .instr1(pi1), .pair_ok(pok));
  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [31:0] d0, input logic [31:0] d1);
    imem_data0 = d0;
    imem_data1 = d1;
    @(posedge clk);
    #1;
  endtask
  task automatic pc_case(input string tag, input logic [31:0] a, input logic [31:0] b, input logic exp);
    pi0 = a;
    pi1 = b;
    #1;
    check(tag, {31'd0, pok}, {31'd0, exp});
  endtask
  logic [31:0] add3, add4, add5, add9, addi8, lw2, sw3, beq, jr31, jmp, jal;
  initial begin
    add3 = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    add4 = rtype(5'd5, 5'd6, 5'd4, 6'h20);
    add5 = rtype(5'd6, 5'd7, 5'd5, 6'h20);
    add9 = rtype(5'd8, 5'd8, 5'd9, 6'h20);
    addi8 = itype(6'h08, 5'd0, 5'd8, 16'd5);
    lw2 = itype(6'h23, 5'd1, 5'd2, 16'd0);
    sw3 = itype(6'h2B, 5'd4, 5'd3, 16'd4);
    beq = itype(6'h04, 5'd1, 5'd2, 16'd4);
    jr31 = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    jmp = 32'h0800_0010;
    jal = 32'h0C00_0000;
    pc_case("pc_jr0", jr31, add4, 1'b0);
    pc_case("pc_j1", add4, jmp, 1'b0);
    pc_case("pc_jal0", jal, add4, 1'b0);
    pc_case("pc_waw", addi8, itype(6'h0D, 5'd1, 5'd8, 16'd3), 1'b0);
    pc_case("pc_raw_sw_rt", addi8, itype(6'h2B, 5'd1, 5'd8, 16'd0), 1'b0);
    pc_case("pc_raw_rs", add3, itype(6'h23, 5'd3, 5'd2, 16'd0), 1'b0);
    pc_case("pc_indep_i", addi8, itype(6'h08, 5'd2, 5'd9, 16'd1), 1'b1);
    pc_case("pc_unknown", 32'hFC00_0000, add4, 1'b1);
    pc_case("pc_dest0", itype(6'h08, 5'd1, 5'd0, 16'd1), rtype(5'd0, 5'd0, 5'd9, 6'h20), 1'b1);
    pc_case("pc_memmem", lw2, sw3, 1'b0);
    pc_case("pc_lw_add", lw2, add5, 1'b1);
    step(add3, add4);
    check("rst_pc", pc, 32'd0);
    check("rst_v0", {31'd0, ifid_valid0}, 32'd0);
    check("rst_v1", {31'd0, ifid_valid1}, 32'd0);
    check("rst_i0", ifid_instr0, 32'd0);
    check("rst_i1", ifid_instr1, 32'd0);
    check("rst_pc1", ifid_pc1, 32'd0);
    rst = 1'b0;
    step(add3, add4);
    check("p0_v0", {31'd0, ifid_valid0}, 32'd1);
    check("p0_v1", {31'd0, ifid_valid1}, 32'd1);
    check("p0_pc0", ifid_pc0, 32'd0);
    check("p0_pc1", ifid_pc1, 32'd4);
    check("p0_i0", ifid_instr0, add3);
    check("p0_i1", ifid_instr1, add4);
    check("p0_pc", pc, 32'd8);
    check("p0_a0", imem_addr0, 32'd8);
    check("p0_a1", imem_addr1, 32'hC);
    step(add3, add4);
    check("p8_pc", pc, 32'h10);
    step(addi8, add9);
    check("raw_v1", {31'd0, ifid_valid1}, 32'd0);
    check("raw_i1", ifid_instr1, 32'd0);
    check("raw_i0", ifid_instr0, addi8);
    check("raw_pc", pc, 32'h14);
    step(add9, add4);
    check("raw2_pc0", ifid_pc0, 32'h14);
    check("raw2_i0", ifid_instr0, add9);
    check("raw2_pc", pc, 32'h1C);
    step(lw2, sw3);
    check("mem_v1", {31'd0, ifid_valid1}, 32'd0);
    check("mem_pc", pc, 32'h20);
    step(beq, add4);
    check("beq_v0", {31'd0, ifid_valid0}, 32'd1);
    check("beq_v1", {31'd0, ifid_valid1}, 32'd0);
    check("beq_pc", pc, 32'h24);
    redirect = 1'b1;
    stall = 1'b1;
    redirect_pc = 32'h100;
    step(add3, add4);
    check("rd_pc", pc, 32'h100);
    check("rd_v0", {31'd0, ifid_valid0}, 32'd0);
    check("rd_v1", {31'd0, ifid_valid1}, 32'd0);
    check("rd_i0", ifid_instr0, 32'd0);
    redirect = 1'b0;
    stall = 1'b0;
    step(lw2, add5);
    check("lwadd_v1", {31'd0, ifid_valid1}, 32'd1);
    check("lwadd_pc", pc, 32'h108);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step(add3, add4);
    check("rd40_pc", pc, 32'h40);
    redirect = 1'b0;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step($urandom, $urandom);
      check("st_pc", pc, 32'h40);
      check("st_a0", imem_addr0, 32'h40);
      check("st_v0", {31'd0, ifid_valid0}, 32'd0);
    end
    stall = 1'b0;
    step(add3, add4);
    check("rel_pc0", ifid_pc0, 32'h40);
    check("rel_v1", {31'd0, ifid_valid1}, 32'd1);
    check("rel_pc", pc, 32'h48);
    stall = 1'b1;
    step(addi8, add9);
    check("hold_pc", pc, 32'h48);
    check("hold_i0", ifid_instr0, add3);
    check("hold_i1", ifid_instr1, add4);
    check("hold_pc1", ifid_pc1, 32'h44);
    stall = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step(add3, add4);
    redirect = 1'b0;
    step(add3, add4);
    check("wrap_pc", pc, 32'h0);
    check("wrap_pc0", ifid_pc0, 32'hFFFF_FFF8);
    check("wrap_pc1", ifid_pc1, 32'hFFFF_FFFC);
    check("wrap_a1", imem_addr1, 32'h4);
    step(add3, add4);
    check("pre_rst_pc", pc, 32'h8);
    stall = 1'b1;
    rst = 1'b1;
    step(add3, add4);
    check("rst_st_pc", pc, 32'd0);
    check("rst_st_v0", {31'd0, ifid_valid0}, 32'd0);
    check("rst_st_v1", {31'd0, ifid_valid1}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
